// File: rtl/mult_pkg.sv
// Shared widths, FSM state type and helpers for the multiplier arbiter.
package mult_pkg;

  localparam int OP_W         = 16;
  localparam int PROD_W       = 32;
  localparam int BOOTH_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_rr_arbiter_if.sv
// Bundle of requester, multiplier and response signals around the arbiter.
interface mult_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = mult_pkg::id_width(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]                        req;
  logic [NUM_REQ-1:0][mult_pkg::OP_W-1:0]    req_mc;
  logic [NUM_REQ-1:0][mult_pkg::OP_W-1:0]    req_mp;
  logic [NUM_REQ-1:0]                        req_ack;

  // Multiplier side
  logic                                      mult_start;
  logic [mult_pkg::OP_W-1:0]                 mult_mc;
  logic [mult_pkg::OP_W-1:0]                 mult_mp;
  logic                                      mult_busy;
  logic [mult_pkg::PROD_W-1:0]               mult_prod;

  // Response side
  logic                                      resp_valid;
  logic                                      resp_ready;
  logic [ID_W-1:0]                           resp_id;
  logic [mult_pkg::PROD_W-1:0]               resp_prod;
  logic                                      resp_err;

  // Arbiter view
  modport slave (
    input  req, req_mc, req_mp, mult_busy, mult_prod, resp_ready,
    output req_ack, mult_start, mult_mc, mult_mp,
           resp_valid, resp_id, resp_prod, resp_err
  );

  // Environment view (requesters, multiplier and consumer)
  modport master (
    output req, req_mc, req_mp, mult_busy, mult_prod, resp_ready,
    input  req_ack, mult_start, mult_mc, mult_mp,
           resp_valid, resp_id, resp_prod, resp_err
  );

endinterface

// File: rtl/mult_rr_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index,
  output logic               any_req
);

  logic [NUM_REQ-1:0] mask_hi;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick_src;

  // Positions at or above the pointer are searched first.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign mask_hi[gi] = (32'(gi) >= 32'(ptr));
  end

  assign req_hi   = req & mask_hi;
  // Nothing at/after the pointer means the search wraps to bit 0.
  assign pick_src = (|req_hi) ? req_hi : req;
  // Isolate the lowest set bit of the chosen half.
  assign grant    = pick_src & (~pick_src + NUM_REQ'(1));
  assign any_req  = |req;

  // Encode the one-hot grant into an index.
  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) index = ID_W'(i);
    end
  end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NUM_REQ requesters,
// with a watchdog on the multiplier and a valid/ready result port.
module mult_rr_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WDOG_MAX = 24
) (
  input  logic             clk,
  input  logic             rst,
  mult_rr_arbiter_if.slave bus
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam int WD_W = $clog2(WDOG_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_MAX - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [OP_W-1:0]     mc_q, mc_d;
  logic [OP_W-1:0]     mp_q, mp_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                err_q, err_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_picker (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .grant  (pick_grant),
    .index  (pick_idx),
    .any_req(pick_any)
  );

  // Next-state logic: grant, launch, wait on multiplier or watchdog, respond.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    prod_d   = prod_q;
    err_d    = err_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          id_d    = pick_idx;
          mc_d    = bus.req_mc[pick_idx];
          mp_d    = bus.req_mp[pick_idx];
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // busy still reflects the previous operation here, so it is not looked at
        wdog_d  = '0;
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (!bus.mult_busy) begin
          prod_d  = bus.mult_prod;
          err_d   = 1'b0;
          state_d = ST_RESPOND;
        end else if (wdog_q == WD_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          wdog_d  = wdog_q + WD_W'(1);
        end
      end
      ST_RESPOND: begin
        if (bus.resp_ready) begin
          rr_ptr_d = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end

  // Ack is only offered from IDLE and never while reset is held.
  assign bus.req_ack    = (rst && state_q == ST_IDLE) ? pick_grant : '0;
  assign bus.mult_start = (state_q == ST_LAUNCH);
  assign bus.mult_mc    = mc_q;
  assign bus.mult_mp    = mp_q;
  assign bus.resp_valid = (state_q == ST_RESPOND);
  assign bus.resp_id    = id_q;
  assign bus.resp_prod  = prod_q;
  assign bus.resp_err   = err_q;

endmodule

// File: doc/mult_rr_arbiter.md
MULT_RR_ARBITER -- requirements
Module: mult_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one Booth multiplier.
REQ-002 SHALL have parameter WDOG_MAX, default 24, COMPUTE cycles allowed before timeout.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester operation request; held until acked.
REQ-006 SHALL have port req_mc  input  NUM_REQ x 16  per-requester multiplicand.
REQ-007 SHALL have port req_mp  input  NUM_REQ x 16  per-requester multiplier.
REQ-008 SHALL have port req_ack  output  NUM_REQ  one-hot, one-cycle operand-capture pulse.
REQ-009 SHALL have port mult_start  output  1  load pulse to multiplier.
REQ-010 SHALL have port mult_mc, mult_mp  output  16 each  operands to multiplier.
REQ-011 SHALL have port mult_busy  input  1  high while multiplier iterates (count < 16).
REQ-012 SHALL have port mult_prod  input  32  multiplier product {acc, q}.
REQ-013 SHALL have port resp_valid  output  1  result available.
REQ-014 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-015 SHALL have port resp_id  output  log2(NUM_REQ)  index of served requester.
REQ-016 SHALL have port resp_prod  output  32  signed product.
REQ-017 SHALL have port resp_err  output  1  watchdog timeout flag for this result.

Function
REQ-018 SHALL implement FSM IDLE -> LAUNCH -> COMPUTE -> RESPOND -> IDLE; one operation in flight.
REQ-019 In IDLE with any req bit set, SHALL grant the first set bit at or after rr_ptr (wrapping), assert req_ack for that bit in the same cycle, register operands and id, go to LAUNCH.
REQ-020 req_ack SHALL be 0 in every state except IDLE; no grant when req = 0.
REQ-021 In LAUNCH, mult_start SHALL be 1 for exactly one cycle; next state COMPUTE.
REQ-022 mult_mc/mult_mp SHALL hold the granted operands from LAUNCH until the next grant.
REQ-023 COMPUTE SHALL ignore mult_busy in the LAUNCH cycle; it SHALL leave on the first cycle mult_busy = 0, registering mult_prod into resp_prod with resp_err = 0.
REQ-024 Latency: ack in cycle T -> mult_start in T+1 -> resp_valid first high in T+19 (16 Booth iterations).
REQ-025 A watchdog SHALL count COMPUTE cycles; on reaching WDOG_MAX with mult_busy still 1, it SHALL go to RESPOND with resp_prod = 0 and resp_err = 1.
REQ-026 In RESPOND, resp_valid, resp_id, resp_prod and resp_err SHALL stay stable until resp_valid & resp_ready; then next state IDLE.
REQ-027 On the handshake, rr_ptr SHALL become (granted id + 1) mod NUM_REQ; a deasserted requester never blocks others.
REQ-028 Back-to-back: a request pending at handshake SHALL be acked in the first IDLE cycle (one-cycle IDLE bubble).
REQ-029 req bits arriving in LAUNCH/COMPUTE/RESPOND SHALL wait; they SHALL not change the active operation.

Reset
REQ-030 When rst = 0 at a clock edge: state = IDLE, rr_ptr = 0, watchdog = 0, resp_valid = 0, resp_err = 0, resp_id = 0, resp_prod = 0, mult_start = 0, mult_mc = mult_mp = 0, req_ack = 0.
REQ-031 Reset mid-operation SHALL discard the in-flight result silently; no response for it.

Structure
REQ-032 Package mult_pkg SHALL hold OP_W = 16, PROD_W = 32, BOOTH_CYCLES = 16 and the FSM state enum.
REQ-033 Round-robin pick SHALL be a sub-module rr_picker (req, ptr -> one-hot grant, index, any).

Verification
REQ-034 Single: req[2], mc = 7, mp = -3 -> ack[2] in T, resp_valid in T+19, resp_prod = -21, resp_id = 2, resp_err = 0.
REQ-035 Contention: req = 4'b1111 held, resp_ready = 1 -> served ids 0, 1, 2, 3, 0 in order.
REQ-036 Backpressure: resp_ready = 0 for 10 cycles after resp_valid -> outputs stable, no new ack; then 1 -> IDLE next cycle.
REQ-037 Extremes: mc = -32768, mp = -32768 -> resp_prod = 0x40000000; mc = 0x7FFF, mp = 0 -> 0.
REQ-038 Watchdog: mult_busy forced to 1 -> resp_valid at COMPUTE cycle 24 with resp_err = 1, resp_prod = 0.
REQ-039 Reset mid-COMPUTE -> no resp_valid, rr_ptr = 0, and the next req[3] is served normally.
